lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the control unit. It consumes mem_op, mem_read_type and mem_write_mask, plus the ALU-computed address and the rs2 store data.
- Runs one data-memory transaction per request over a req/ack bus.
- Aligns and byte-masks store data; extracts and sign- or zero-extends load data.
- Flags misaligned accesses and bus timeouts back to the core sequencer.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in ACCESS without bus_ack before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  start a transaction; sampled only in IDLE
- mem_op  in  2  `MEM_OP_LOAD / `MEM_OP_STORE / `MEM_OP_NONE
- mem_read_type  in  3  `MEM_RD_* load type
- mem_write_mask  in  4  `MEM_WR_* unshifted byte mask
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result; valid while done=1
- misaligned  out  1  with done: alignment fault, no bus access made
- bus_err  out  1  with done: timeout fault
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes
- bus_ack  in  1  transfer complete; bus_rdata valid in the same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE.
  - All outputs 0: busy, done, load_data, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb.
  - Timeout counter cleared.
  - An in-flight transaction is abandoned; bus_req is low from the following cycle.
- Write mask encodings (defines.v): `MEM_WR_BYTE=4'b0001, `MEM_WR_HALF=4'b0011, `MEM_WR_WORD=4'b1111, `MEM_WR_NONE=4'b0000.
- FSM states: IDLE, ACCESS, DONE, FAULT.
- IDLE, req_valid=1:
  - Latch op, type, mask, addr[1:0], wdata.
  - Alignment fault (-> FAULT): half access with addr[0]=1; word access with addr[1:0]!=0.
  - mem_op=NONE: go to DONE with no bus access; load_data=0.
  - Otherwise go to ACCESS; bus_req, bus_we, bus_addr, bus_wdata and bus_wstrb are registered and valid from the first ACCESS cycle.
- req_valid while busy is ignored and is not queued.
- ACCESS:
  - bus_req=1 and all bus outputs held stable until exit.
  - bus_ack=1: capture the extended bus_rdata into load_data (loads only), drop bus_req next cycle, go to DONE.
  - Counter increments each ACCESS cycle without ack. When counter==TIMEOUT_CYCLES-1 and no ack: go to DONE with bus_err=1, load_data=0.
  - Ack in the same cycle as timeout expiry: the ack wins, bus_err=0.
- DONE: done=1 for exactly one cycle, then IDLE. misaligned and bus_err are only meaningful with done and read 0 otherwise.
- FAULT: done=1 and misaligned=1 for one cycle, then IDLE. bus_req is never raised.
- Latency: request in cycle N; bus_req from N+1; ack in cycle M gives done in M+1. Minimum request-to-done is 2 cycles (ack in N+1 gives done in N+2).
- Store data path:
  - bus_wstrb = mask << addr[1:0].
  - Byte: bus_wdata = {4{wdata[7:0]}}. Half: {2{wdata[15:0]}}. Word: wdata.
  - Loads use bus_wstrb=0, bus_we=0.
- Load extract (sh = addr[1:0]*8):
  - BYTE: sign-extend bus_rdata[sh+:8]. B_U: zero-extend the same byte.
  - HALF: sign-extend bus_rdata[sh+:16]. H_U: zero-extend the same half.
  - WORD: bus_rdata unchanged.
  - `MEM_RD_NONE with LOAD: treat as WORD (control unit flags it invalid upstream).
- bus_ack while not in ACCESS (late ack after timeout or reset) is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- MEM_OP_*, MEM_RD_*, MEM_WR_* stay in defines.v.
- Add LSU_ST_IDLE/ACCESS/DONE/FAULT state codes and LSU_DEFAULT_TIMEOUT to defines.v.
- One sub-module: lsu_load_align. It is combinational: bus_rdata, addr[1:0], read type in; 32-bit extended word out. It is reused by the bench's reference model.

Test Plan:
- Store byte: addr=0x1003, wdata=0xA5 -> bus_addr=0x1000, bus_wstrb=4'b1000, bus_wdata=0xA5A5A5A5, bus_we=1. Ack in 1st ACCESS cycle -> done 2 cycles after request.
- Load LB: addr=0x2002, bus_rdata=0x12F0_5678 -> load_data=0xFFFF_FFF0. Same access with LBU -> 0x0000_00F0. LHU at 0x2002 -> 0x0000_12F0.
- Misaligned LW at 0x3001 -> FAULT: done=1, misaligned=1 one cycle later, bus_req never high. Misaligned SH at 0x3003 -> same response.
- Timeout: TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then done=1, bus_err=1. Ack on the 4th ACCESS cycle instead -> bus_err=0, data captured.
- Back-to-back: req_valid held high for 5 cycles during a 3-cycle-ack load -> exactly one transaction. A second transaction starts from the IDLE cycle after done.
- Reset mid-ACCESS: rst=1 for 1 cycle -> next cycle bus_req=0, busy=0, done=0. A later bus_ack in IDLE produces no done.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store unit: memory op, load type, write mask,
// FSM state codes, default timeout, and the small store/alignment helpers.
package lsu_mem_stage_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_RD_NONE = 3'b000;
    localparam logic [2:0] MEM_RD_BYTE = 3'b001;
    localparam logic [2:0] MEM_RD_HALF = 3'b010;
    localparam logic [2:0] MEM_RD_WORD = 3'b011;
    localparam logic [2:0] MEM_RD_B_U  = 3'b100;
    localparam logic [2:0] MEM_RD_H_U  = 3'b101;

    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    localparam int LSU_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        LSU_ST_IDLE   = 2'b00,
        LSU_ST_ACCESS = 2'b01,
        LSU_ST_DONE   = 2'b10,
        LSU_ST_FAULT  = 2'b11
    } lsu_state_e;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    // A load with MEM_RD_NONE behaves as a word load, so it aligns as one.
    function automatic logic lsu_is_misaligned(input logic [1:0] op,
                                               input logic [2:0] rd_type,
                                               input logic [3:0] mask,
                                               input logic [1:0] off);
        logic is_half;
        logic is_word;
        is_half = 1'b0;
        is_word = 1'b0;
        if (op == MEM_OP_LOAD) begin
            is_half = (rd_type == MEM_RD_HALF) || (rd_type == MEM_RD_H_U);
            is_word = (rd_type == MEM_RD_WORD) || (rd_type == MEM_RD_NONE);
        end else if (op == MEM_OP_STORE) begin
            is_half = (mask == MEM_WR_HALF);
            is_word = (mask == MEM_WR_WORD);
        end else begin
            is_half = 1'b0;
            is_word = 1'b0;
        end
        return (is_half && off[0]) || (is_word && (off != 2'b00));
    endfunction

    // Replicate the store data across every lane it might land in.
    function automatic logic [31:0] lsu_store_lanes(input logic [3:0] mask,
                                                    input logic [31:0] wdata);
        logic [31:0] lanes;
        case (mask)
            MEM_WR_BYTE: lanes = {4{wdata[7:0]}};
            MEM_WR_HALF: lanes = {2{wdata[15:0]}};
            default:     lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load extractor: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  rd_type,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend per load type.
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        case (rd_type)
            MEM_RD_BYTE: data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            MEM_RD_B_U:  data = {24'h000000, shifted_s[7:0]};
            MEM_RD_HALF: data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            MEM_RD_H_U:  data = {16'h0000, shifted_s[15:0]};
            default:     data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one req/ack bus transaction per request, with store
// lane steering, load extension, alignment faults and an access timeout.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] aligned_s;

    lsu_load_align u_load_align (
        .rdata   (bus_rdata),
        .off     (off_q),
        .rd_type (rd_type_q),
        .data    (aligned_s)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_type_d    = rd_type_q;
        off_d        = off_q;
        is_load_d    = is_load_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (req_valid) begin
                    rd_type_d   = mem_read_type;
                    off_d       = addr[1:0];
                    is_load_d   = (mem_op == MEM_OP_LOAD);
                    load_data_d = 32'h0000_0000;
                    cnt_d       = {CW{1'b0}};
                    busy_d      = 1'b1;
                    if (lsu_is_misaligned(mem_op, mem_read_type, mem_write_mask, addr[1:0])) begin
                        state_d      = LSU_ST_FAULT;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else if ((mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE)) begin
                        state_d    = LSU_ST_ACCESS;
                        bus_req_d  = 1'b1;
                        bus_we_d   = (mem_op == MEM_OP_STORE);
                        bus_addr_d = {addr[31:2], 2'b00};
                        if (mem_op == MEM_OP_STORE) begin
                            bus_wdata_d = lsu_store_lanes(mem_write_mask, wdata);
                            bus_wstrb_d = mem_write_mask << addr[1:0];
                        end else begin
                            bus_wdata_d = 32'h0000_0000;
                            bus_wstrb_d = 4'b0000;
                        end
                    end else begin
                        state_d = LSU_ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = LSU_ST_IDLE;
                end
            end
            LSU_ST_ACCESS: begin
                if (bus_ack || ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST))) begin
                    // Ack has priority over a timeout expiring in the same cycle.
                    state_d     = LSU_ST_DONE;
                    done_d      = 1'b1;
                    bus_err_d   = ~bus_ack;
                    load_data_d = (bus_ack && is_load_q) ? aligned_s : 32'h0000_0000;
                    cnt_d       = {CW{1'b0}};
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0000_0000;
                    bus_wdata_d = 32'h0000_0000;
                    bus_wstrb_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            LSU_ST_DONE, LSU_ST_FAULT: begin
                state_d = LSU_ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = LSU_ST_IDLE;
                busy_d      = 1'b0;
                bus_req_d   = 1'b0;
                bus_we_d    = 1'b0;
                bus_addr_d  = 32'h0000_0000;
                bus_wdata_d = 32'h0000_0000;
                bus_wstrb_d = 4'b0000;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_ST_IDLE;
            cnt_q        <= {CW{1'b0}};
            rd_type_q    <= 3'b000;
            off_q        <= 2'b00;
            is_load_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0000_0000;
            bus_wdata_q  <= 32'h0000_0000;
            bus_wstrb_q  <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_type_q    <= rd_type_d;
            off_q        <= off_d;
            is_load_q    <= is_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with hand-computed expected values.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  mem_op;
    logic [2:0]  mem_read_type;
    logic [3:0]  mem_write_mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic [31:0] ua_rdata;
    logic [1:0]  ua_off;
    logic [2:0]  ua_type;
    logic [31:0] ua_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_ld, r_addr, r_wdata;
    logic        r_err, r_mis, r_we;
    logic [3:0]  r_strb;
    int          r_done_cyc, r_req_cyc;
    int          n_done, n_rise;
    logic        prev_req;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op),
        .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    lsu_load_align u_align (.rdata(ua_rdata), .off(ua_off), .rd_type(ua_type), .data(ua_data));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; ack on the ack_at-th ACCESS cycle (0 = never).
    task automatic run_txn(input logic [1:0] op, input logic [2:0] rt, input logic [3:0] mask,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_at);
        req_valid = 1'b1; mem_op = op; mem_read_type = rt; mem_write_mask = mask;
        addr = a; wdata = wd;
        step();
        req_valid = 1'b0; mem_op = MEM_OP_NONE;
        r_done_cyc = -1; r_req_cyc = 0;
        r_ld = 32'h0; r_err = 1'b0; r_mis = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) begin
                r_addr = bus_addr; r_wdata = bus_wdata; r_strb = bus_wstrb; r_we = bus_we;
            end
            if (done) begin
                r_done_cyc = c; r_ld = load_data; r_err = bus_err; r_mis = misaligned;
                break;
            end
            if (bus_req) r_req_cyc++;
            if ((ack_at != 0) && (c == ack_at)) begin
                bus_ack = 1'b1; bus_rdata = rd;
            end else begin
                bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
            end
            step();
        end
        bus_ack = 1'b0;
        chk("txn_bound", {31'h0, (r_done_cyc > 0)}, 32'h1);
        if (r_done_cyc > 0) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_op = MEM_OP_NONE; mem_read_type = MEM_RD_NONE;
        mem_write_mask = MEM_WR_NONE; addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        step(); step();
        chk("rst_ctrl", {26'h0, busy, done, misaligned, bus_err, bus_req, bus_we}, 32'h0);
        chk("rst_data", load_data | bus_addr | bus_wdata | {28'h0, bus_wstrb}, 32'h0);
        rst = 1'b0;
        step();

        // Standalone extractor checks.
        ua_rdata = 32'h8001_FFFF; ua_off = 2'd0; ua_type = MEM_RD_H_U; #1;
        chk("align_hu", ua_data, 32'h0000_FFFF);
        ua_rdata = 32'h0000_8000; ua_off = 2'd1; ua_type = MEM_RD_BYTE; #1;
        chk("align_b1", ua_data, 32'hFFFF_FF80);

        // Store byte at 0x1003.
        run_txn(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_BYTE, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1);
        chk("sb_addr", r_addr, 32'h0000_1000);
        chk("sb_strb", {28'h0, r_strb}, 32'h8);
        chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'h0, r_we}, 32'h1);
        chk("sb_lat", r_done_cyc, 32'd2);
        chk("sb_ld", r_ld, 32'h0);

        // Store half at 0x1002.
        run_txn(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_HALF, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 2);
        chk("sh_strb", {28'h0, r_strb}, 32'hC);
        chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);

        // Loads at 0x2002.
        run_txn(MEM_OP_LOAD, MEM_RD_BYTE, MEM_WR_NONE, 32'h0000_2002, 32'h0, 32'h12F0_5678, 1);
        chk("lb_data", r_ld, 32'hFFFF_FFF0);
        chk("lb_we_strb", {27'h0, r_we, r_strb}, 32'h0);
        chk("lb_addr", r_addr, 32'h0000_2000);
        run_txn(MEM_OP_LOAD, MEM_RD_B_U, MEM_WR_NONE, 32'h0000_2002, 32'h0, 32'h12F0_5678, 1);
        chk("lbu_data", r_ld, 32'h0000_00F0);
        run_txn(MEM_OP_LOAD, MEM_RD_H_U, MEM_WR_NONE, 32'h0000_2002, 32'h0, 32'h12F0_5678, 1);
        chk("lhu_data", r_ld, 32'h0000_12F0);
        run_txn(MEM_OP_LOAD, MEM_RD_HALF, MEM_WR_NONE, 32'h0000_2000, 32'h0, 32'h1234_8001, 1);
        chk("lh_data", r_ld, 32'hFFFF_8001);
        run_txn(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 3);
        chk("lw_data", r_ld, 32'hDEAD_BEEF);
        chk("lw_lat", r_done_cyc, 32'd4);
        chk("lw_req", r_req_cyc, 32'd3);
        run_txn(MEM_OP_LOAD, MEM_RD_NONE, MEM_WR_NONE, 32'h0000_2008, 32'h0, 32'h8765_4321, 1);
        chk("lnone_data", r_ld, 32'h8765_4321);

        // Misaligned accesses.
        run_txn(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h0000_3001, 32'h0, 32'h0, 1);
        chk("mlw_resp", {29'h0, r_mis, r_err, 1'b0}, 32'h4);
        chk("mlw_lat", r_done_cyc, 32'd1);
        chk("mlw_req", r_req_cyc, 32'd0);
        run_txn(MEM_OP_STORE, MEM_RD_NONE, MEM_WR_HALF, 32'h0000_3003, 32'h0, 32'h0, 1);
        chk("msh_resp", {30'h0, r_mis, r_err}, 32'h2);
        chk("msh_req", r_req_cyc + r_done_cyc, 32'd1);

        // No-op request.
        run_txn(MEM_OP_NONE, MEM_RD_NONE, MEM_WR_NONE, 32'h0000_4000, 32'h0, 32'h0, 1);
        chk("nop_resp", {r_ld[31:2], r_mis, r_err}, 32'h0);
        chk("nop_req", r_req_cyc, 32'd0);

        // Timeout, then ack on the last cycle before expiry.
        run_txn(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h0000_5000, 32'h0, 32'h1111_2222, 0);
        chk("to_req", r_req_cyc, 32'd4);
        chk("to_err", {31'h0, r_err}, 32'h1);
        chk("to_ld", r_ld, 32'h0);
        run_txn(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h0000_5000, 32'h0, 32'h1111_2222, 4);
        chk("ack4_err", {31'h0, r_err}, 32'h0);
        chk("ack4_ld", r_ld, 32'h1111_2222);

        // req_valid held for 5 cycles during a 3-cycle-ack load.
        req_valid = 1'b1; mem_op = MEM_OP_LOAD; mem_read_type = MEM_RD_WORD; addr = 32'h0000_0040;
        n_done = 0; n_rise = 0; prev_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 5) req_valid = 1'b0;
            if (done) begin
                n_done++;
                chk("b2b_ld", load_data, 32'hCAFE_0001);
            end
            if (bus_req && !prev_req) n_rise++;
            prev_req = bus_req;
            bus_ack = (c == 3);
            bus_rdata = (c == 3) ? 32'hCAFE_0001 : 32'hFFFF_FFFF;
        end
        bus_ack = 1'b0;
        chk("b2b_done", n_done, 32'd1);
        chk("b2b_rise", n_rise, 32'd1);
        run_txn(MEM_OP_LOAD, MEM_RD_WORD, MEM_WR_NONE, 32'h0000_0044, 32'h0, 32'h0000_0077, 1);
        chk("b2b_second", r_ld, 32'h0000_0077);
        chk("b2b_lat", r_done_cyc, 32'd2);

        // Reset in the middle of ACCESS, then a stray ack.
        req_valid = 1'b1; mem_op = MEM_OP_LOAD; mem_read_type = MEM_RD_WORD; addr = 32'h0000_0050;
        step();
        req_valid = 1'b0;
        chk("mid_req", {31'h0, bus_req}, 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst", {29'h0, bus_req, busy, done}, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        step();
        bus_ack = 1'b0;
        chk("late_ack1", {30'h0, done, busy}, 32'h0);
        step();
        chk("late_ack2", {30'h0, done, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
